// File: rtl/adsr_envelope.sv
// adsr_envelope
// -----------------------------------------------------------------------------
// Amplitude-envelope stage between the wave generator and the PWM audio output.
// A 16-bit accumulator is stepped through ATTACK / DECAY / SUSTAIN / RELEASE
// on a slow envelope tick (one tick every TICK_DIV clocks). Its upper byte is
// the envelope level, and it scales the incoming sample about its 0x80
// midpoint.
//
// Ports
//   clk            system clock (100 MHz)
//   rst            synchronous, active-high reset
//   gate           note on (1) / off (0), already debounced, synchronous to clk
//   attack_rate    accumulator increment per tick in ATTACK (0 = jump to full)
//   decay_rate     accumulator decrement per tick in DECAY (0 = jump to sustain)
//   sustain_level  sustain envelope level (upper byte of the accumulator)
//   release_rate   accumulator decrement per tick in RELEASE (0 = jump to zero)
//   wave_in        unsigned sample from the generator, midpoint 0x80
//   wave_out       registered, scaled unsigned sample to the PWM stage
//   env_level      current envelope level, acc[15:8]
//   state          IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   active         high whenever state != IDLE
// -----------------------------------------------------------------------------
module adsr_envelope #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  input  logic [7:0] wave_in,
  output logic [7:0] wave_out,
  output logic [7:0] env_level,
  output logic [2:0] state,
  output logic       active
);

  localparam int unsigned          CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gate_q, gate_d;
  logic [7:0]         wave_out_q, wave_out_d;

  logic               tick;
  logic               rise;
  logic [15:0]        sustain_acc;
  logic [16:0]        attack_sum;
  logic [16:0]        decay_diff;
  logic               attack_full;
  logic               decay_done;
  logic               release_done;
  logic signed [16:0] centered;
  logic signed [16:0] product;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      gate_q     <= 1'b0;
      wave_out_q <= 8'h80;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      gate_q     <= gate_d;
      wave_out_q <= wave_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / accumulator logic
  // ---------------------------------------------------------------------------
  always_comb begin
    tick        = (cnt_q == CNT_MAX);
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    gate_d      = gate;
    rise        = gate & ~gate_q;
    sustain_acc = {sustain_level, 8'h00};

    // 17-bit arithmetic exposes carry / borrow for saturation and underflow.
    attack_sum   = {1'b0, acc_q} + {9'b0, attack_rate};
    decay_diff   = {1'b0, acc_q} - {9'b0, decay_rate};
    attack_full  = (attack_rate == '0) | attack_sum[16] | (attack_sum[15:0] == 16'hFFFF);
    decay_done   = (decay_rate == '0) | decay_diff[16] | (decay_diff[15:0] <= sustain_acc);
    release_done = (release_rate == '0) | (acc_q <= {8'h00, release_rate});

    state_d = state_q;
    acc_d   = acc_q;

    // Gate events are tested ahead of the tick so that a gate transition
    // suppresses the tick arithmetic for that cycle.
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (rise) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          if (attack_full) begin
            acc_d   = '1;
            state_d = ST_DECAY;
          end else begin
            acc_d = attack_sum[15:0];
          end
        end
      end
      ST_DECAY: begin
        if (!gate) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          if (decay_done) begin
            acc_d   = sustain_acc;
            state_d = ST_SUSTAIN;
          end else begin
            acc_d = decay_diff[15:0];
          end
        end
      end
      ST_SUSTAIN: begin
        // Tracks sustain_level every cycle so level changes apply live.
        acc_d = sustain_acc;
        if (!gate) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Retrigger keeps the current accumulator; attack resumes from here.
        if (rise) begin
          state_d = ST_ATTACK;
        end else if (tick) begin
          if (release_done) begin
            acc_d   = '0;
            state_d = ST_IDLE;
          end else begin
            acc_d = acc_q - {8'h00, release_rate};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    env_level = acc_q[15:8];
    state     = state_q;
    active    = (state_q != ST_IDLE);
    wave_out  = wave_out_q;

    // Centre the sample, scale by the unsigned level, floor-shift back down
    // and re-bias. Magnitudes stay within 17-bit signed, result within 0..254.
    centered   = $signed({9'b0, wave_in}) - 17'sd128;
    product    = centered * $signed({9'b0, env_level});
    wave_out_d = 8'((product >>> 8) + 17'sd128);
  end

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

  localparam int TD         = 4;
  localparam int PH_IDLE    = 0;
  localparam int PH_ATTACK  = 1;
  localparam int PH_DECAY   = 2;
  localparam int PH_SUSTAIN = 3;
  localparam int PH_RELEASE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       gate;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [7:0] sustain_level;
  logic [7:0] release_rate;
  logic [7:0] wave_in;
  logic [7:0] wave_out;
  logic [7:0] env_level;
  logic [2:0] state;
  logic       active;

  int total = 0;
  int bad   = 0;

  // Reference model: envelope phase, accumulator value, tick phase, last gate.
  int m_phase = 0;
  int m_acc   = 0;
  int m_cnt   = 0;
  int m_wave  = 128;
  bit m_gate_prev = 1'b0;

  adsr_envelope #(.TICK_DIV(TD)) dut (
    .clk           (clk),
    .rst           (rst),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .wave_in       (wave_in),
    .wave_out      (wave_out),
    .env_level     (env_level),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  function automatic int floor_div256(int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  function automatic logic [19:0] expected_vec();
    logic [19:0] v;
    v[19:17] = 3'(m_phase);
    v[16]    = (m_phase != PH_IDLE);
    v[15:8]  = 8'(m_acc / 256);
    v[7:0]   = 8'(m_wave);
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit tick;
    bit rise;
    int target;
    if (rst) begin
      m_phase = PH_IDLE; m_acc = 0; m_cnt = 0; m_gate_prev = 1'b0; m_wave = 128;
      return;
    end
    tick   = (m_cnt == TD - 1);
    m_cnt  = (m_cnt + 1) % TD;
    m_wave = floor_div256((int'(wave_in) - 128) * (m_acc / 256)) + 128;
    rise   = gate && !m_gate_prev;
    m_gate_prev = gate;
    target = int'(sustain_level) * 256;
    case (m_phase)
      PH_IDLE: begin
        m_acc = 0;
        if (rise) m_phase = PH_ATTACK;
      end
      PH_ATTACK: begin
        if (!gate) m_phase = PH_RELEASE;
        else if (tick) begin
          if (attack_rate == 0 || m_acc + int'(attack_rate) >= 65535) begin
            m_acc = 65535; m_phase = PH_DECAY;
          end else m_acc = m_acc + int'(attack_rate);
        end
      end
      PH_DECAY: begin
        if (!gate) m_phase = PH_RELEASE;
        else if (tick) begin
          if (decay_rate == 0 || m_acc - int'(decay_rate) <= target) begin
            m_acc = target; m_phase = PH_SUSTAIN;
          end else m_acc = m_acc - int'(decay_rate);
        end
      end
      PH_SUSTAIN: begin
        m_acc = target;
        if (!gate) m_phase = PH_RELEASE;
      end
      default: begin
        if (rise) m_phase = PH_ATTACK;
        else if (tick) begin
          if (release_rate == 0 || m_acc <= int'(release_rate)) begin
            m_acc = 0; m_phase = PH_IDLE;
          end else m_acc = m_acc - int'(release_rate);
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gate = 1'b1; wave_in = 8'hFF;
    attack_rate = 8'h80; decay_rate = 8'hFF; sustain_level = 8'h40; release_rate = 8'h40;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      total++;
      if ({wave_out, env_level, state, active} !== {8'h80, 8'h00, 3'd0, 1'b0}) begin
        bad++;
        $display("FAIL reset_values: got wave_out=%h env=%h state=%0d active=%b, want 80 00 0 0",
                 wave_out, env_level, state, active);
      end
    end
    rst = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      step();
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL reset_exit: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL attack_entry: got state=%0d want 1", state);
    end
  endtask

  task automatic test_attack();
    int cycles = 0;
    while (m_phase == PH_ATTACK && cycles < 3000) begin
      wave_in = 8'($urandom);
      step();
      cycles++;
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL attack_track: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
    total++;
    if (cycles >= 3000) begin
      bad++;
      $display("FAIL attack_timeout: got cycles=%0d want <3000", cycles);
    end
    total++;
    if ({state, env_level} !== {3'd2, 8'hFF}) begin
      bad++;
      $display("FAIL attack_peak: got state=%0d env=%h want 2 ff", state, env_level);
    end
  endtask

  task automatic test_decay_sustain();
    int cycles = 0;
    while (m_phase == PH_DECAY && cycles < 1000) begin
      wave_in = 8'($urandom);
      step();
      cycles++;
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL decay_track: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
    // 193 ticks at 4 clocks each, starting right after the tick that hit full.
    total++;
    if (cycles != 772) begin
      bad++;
      $display("FAIL decay_duration: got cycles=%0d want 772", cycles);
    end
    total++;
    if ({state, env_level} !== {3'd3, 8'h40}) begin
      bad++;
      $display("FAIL sustain_reached: got state=%0d env=%h want 3 40", state, env_level);
    end
    sustain_level = 8'h20;
    step();
    total++;
    if ({state, env_level} !== {3'd3, 8'h20}) begin
      bad++;
      $display("FAIL sustain_live: got state=%0d env=%h want 3 20", state, env_level);
    end
  endtask

  task automatic test_scaling();
    logic [7:0] win  [5];
    logic [7:0] wexp [5];
    win  = '{8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00};
    wexp = '{8'h9F, 8'h60, 8'h80, 8'hFE, 8'h00};
    sustain_level = 8'h40;
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      if (i == 3) begin
        sustain_level = 8'hFF;
        step();
      end
      wave_in = win[i];
      step();
      total++;
      if (wave_out !== wexp[i]) begin
        bad++;
        $display("FAIL scaling_%0d: wave_in=%h env=%h got wave_out=%h want %h",
                 i, wave_in, env_level, wave_out, wexp[i]);
      end
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL scaling_model: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
  endtask

  task automatic test_release_retrigger();
    int cycles = 0;
    sustain_level = 8'h40; release_rate = 8'h40;
    step();
    gate = 1'b0;
    do begin
      wave_in = 8'($urandom);
      step();
      cycles++;
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL release_track: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end while (m_phase != PH_IDLE && cycles < 1200);
    total++;
    if ({state, active, env_level} !== {3'd0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL release_idle: got state=%0d active=%b env=%h want 0 0 00", state, active, env_level);
    end
    // One gate-fall edge, then 256 ticks whose first one lands 1..4 edges later.
    total++;
    if (cycles < 1022 || cycles > 1025) begin
      bad++;
      $display("FAIL release_duration: got cycles=%0d want 1022..1025", cycles);
    end

    attack_rate = 8'h00; decay_rate = 8'h00; gate = 1'b1; cycles = 0;
    while (m_phase != PH_SUSTAIN && cycles < 40) begin
      step();
      cycles++;
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL reattack_track: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
    attack_rate = 8'h80; gate = 1'b0; cycles = 0;
    while (m_acc != 16'h2000 && cycles < 800) begin
      step();
      cycles++;
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL release2_track: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
    gate = 1'b1;
    step();
    total++;
    if ({state, env_level} !== {3'd1, 8'h20}) begin
      bad++;
      $display("FAIL retrigger_hold: got state=%0d env=%h want 1 20", state, env_level);
    end
    for (int unsigned i = 0; i < 12; i++) begin
      step();
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL retrigger_track: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
    // Three ticks of 0x80 on top of 0x2000.
    total++;
    if (env_level !== 8'h21) begin
      bad++;
      $display("FAIL retrigger_resume: got env=%h want 21", env_level);
    end
  endtask

  task automatic test_rate0_reset();
    int cycles = 0;
    rst = 1'b1; gate = 1'b0;
    step();
    rst = 1'b0; attack_rate = 8'h00; decay_rate = 8'h00;
    sustain_level = 8'($urandom_range(1, 254));
    step();
    gate = 1'b1;
    while (m_phase != PH_DECAY && cycles < 20) begin
      step();
      cycles++;
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL rate0_attack_track: got %h want %h", {state, active, env_level, wave_out}, expected_vec());
      end
    end
    total++;
    if ({state, env_level} !== {3'd2, 8'hFF}) begin
      bad++;
      $display("FAIL rate0_attack: got state=%0d env=%h want 2 ff", state, env_level);
    end
    cycles = 0;
    while (m_phase != PH_SUSTAIN && cycles < 20) begin
      step();
      cycles++;
    end
    total++;
    if ({state, env_level} !== {3'd3, sustain_level} || cycles != 4) begin
      bad++;
      $display("FAIL rate0_decay: got state=%0d env=%h cycles=%0d want 3 %h 4",
               state, env_level, cycles, sustain_level);
    end
    release_rate = 8'h01; gate = 1'b0;
    for (int unsigned i = 0; i < 10; i++) step();
    total++;
    if (state !== 3'd4) begin
      bad++;
      $display("FAIL midop_release: got state=%0d want 4", state);
    end
    rst = 1'b1; wave_in = 8'hFF;
    step();
    total++;
    if ({wave_out, env_level, state, active} !== {8'h80, 8'h00, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL midop_reset: got wave_out=%h env=%h state=%0d active=%b, want 80 00 0 0",
               wave_out, env_level, state, active);
    end
    rst = 1'b0;
    step();
  endtask

  function automatic logic [7:0] pick_rate();
    if ($urandom_range(0, 3) == 0) return 8'h00;
    return 8'($urandom_range(64, 255));
  endfunction

  task automatic test_random();
    for (int unsigned i = 0; i < 6000; i++) begin
      wave_in = 8'($urandom);
      rst     = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 299) == 0) gate = ~gate;
      if ($urandom_range(0, 99) == 0) attack_rate   = pick_rate();
      if ($urandom_range(0, 99) == 0) decay_rate    = pick_rate();
      if ($urandom_range(0, 99) == 0) release_rate  = pick_rate();
      if ($urandom_range(0, 99) == 0) sustain_level = 8'($urandom);
      step();
      total++;
      if ({state, active, env_level, wave_out} !== expected_vec()) begin
        bad++;
        $display("FAIL random_track: cycle=%0d got %h want %h", i, {state, active, env_level, wave_out}, expected_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_scaling();
    test_release_retrigger();
    test_rate0_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
